// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands on start and adds them LSB first,
// one bit per clock, publishing sum and carry-out only when the last bit is done.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    // Two cascaded half adders on the current LSBs form the full-adder bit.
    logic             w_ha1;
    logic             w_sum_bit;
    logic             w_carry_nxt;
    logic [WIDTH-1:0] w_s_nxt;

    assign w_ha1       = r_a[0] ^ r_b[0];
    assign w_sum_bit   = w_ha1 ^ r_carry;
    assign w_carry_nxt = (r_a[0] & r_b[0]) | (r_carry & w_ha1);
    assign w_s_nxt     = {w_sum_bit, r_s[WIDTH-1:1]};

    assign busy    = r_busy;
    assign done    = r_done;
    assign sum_out = r_sum;
    assign cout    = r_cout;

    // Control FSM and bit-serial datapath; busy/done are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_s     <= w_s_nxt;
                    r_carry <= w_carry_nxt;
                    if (r_cnt == LAST_BIT) begin
                        // Counter parks at the last index; it is cleared on the next accept.
                        r_sum   <= w_s_nxt;
                        r_cout  <= w_carry_nxt;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
